mrelbp_r8_sample_packer: RTL and testbench
==========================================

MRELBP_R8_SAMPLE_PACKER -- requirements
Module: mrelbp_r8_sample_packer

Interface
REQ-001 Parameter: DATA_W, default 8, width of each sample and each S output.
REQ-002 Parameter: N_SAMPLES, fixed at 17, number of samples per neighbourhood bundle (S1..S17).
REQ-003 Parameter: CNT_W, default 16, width of the bundle counter.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 sample_i  input  DATA_W  serial sample, in S1-first order.
REQ-007 valid_i  input  1  sample_i is valid this cycle; no backpressure, the block accepts every valid cycle.
REQ-008 last_i  input  1  marks the final sample of a frame; meaningful only with valid_i=1.
REQ-009 S1..S17  output  DATA_W each  parallel bundle for the MRELBP CI R8 stage; registered; held between bundles.
REQ-010 done_o  output  1  one-cycle strobe: S1..S17 carry a new complete bundle; drives the CI stage done_i.
REQ-011 frame_done_o  output  1  one-cycle strobe at frame end.
REQ-012 bundle_cnt_o  output  CNT_W  bundles emitted in the current frame; saturates at all-ones.
REQ-013 err_o  output  1  sticky flag: a frame ended mid-bundle.

Function
REQ-014 FSM states: IDLE and FILL.
  - IDLE: no frame open; slot index = 0.
  - The first valid_i moves IDLE -> FILL.
  - Accepting last_i moves the FSM to IDLE.
REQ-015 Slot index counts 0..16.
  - Each valid_i stores sample_i in shadow[idx] and increments idx.
  - idx wraps to 0 after slot 16.
REQ-016 When the sample accepted is in slot 16, the next rising edge:
  - loads S1..S17 from shadow[0..15] plus that sample;
  - asserts done_o for exactly one cycle.
  - Latency: done_o high the cycle after the 17th sample.
REQ-017 At full input rate, done_o pulses every 17 cycles with no lost samples.
  - The shadow register refills while the output registers hold the previous bundle.
REQ-018 bundle_cnt_o increments in the cycle done_o rises.
  - Resets to 0 on the first valid_i of a new frame, i.e. the IDLE->FILL transition.
REQ-019 last_i on slot 16: done_o and frame_done_o assert in the same cycle, and idx returns to 0.
REQ-020 last_i on slot <16 is handled per the Configuration section; in either case frame_done_o pulses one cycle later and idx returns to 0.
REQ-021 Gaps (valid_i=0) in FILL leave idx and shadow unchanged.
REQ-022 last_i with valid_i=0 is ignored.
REQ-023 S1..S17 change only on done_o cycles.

Reset
REQ-024 Asserting rst at any time, including mid-bundle, immediately sets:
  - FSM = IDLE, idx = 0;
  - shadow and S1..S17 = 0;
  - done_o = frame_done_o = err_o = 0;
  - bundle_cnt_o = 0.
REQ-025 A partial bundle interrupted by reset is discarded; no done_o follows reset release.
REQ-026 err_o clears only on reset.

Configuration
REQ-027 Macro: MRELBP_SAMPLER_ZERO_PAD_EN.
  - Defined: a partial bundle at last_i is zero-padded in its unfilled S slots and emitted with done_o; err_o is not set.
  - Undefined: the partial bundle is discarded, no done_o is issued, err_o is set.

Structure
REQ-028 A shared package mrelbp_pkg holds:
  - DATA_W default;
  - N_SAMPLES=17;
  - FSM state encoding (IDLE, FILL).
REQ-029 One sub-module, mrelbp_slot_counter: the 0..16 wrapping index with wrap and terminal flags.

Verification
REQ-030 Ramp test: after reset release, feed 17 contiguous valid samples 10,20,...,170 -> done_o high one cycle after sample 170; S1=10, S17=170; bundle_cnt_o=1.
REQ-031 Back-to-back frame: 34 contiguous samples 1..34 with last_i on 34.
  - done_o pulses at cycles 18 and 35 after the first sample.
  - Second bundle S1=18, S17=34.
  - frame_done_o coincides with the second done_o; bundle_cnt_o=2.
REQ-032 Gaps: 17 samples with valid_i deasserted every other cycle -> a single done_o after the 17th accepted sample, identical S contents.
REQ-033 Partial frame: 5 samples (value 7) with last_i on the 5th.
  - Macro undefined: no done_o, frame_done_o pulses, err_o=1.
  - Macro defined: done_o with S1..S5=7, S6..S17=0, err_o=0.
REQ-034 Mid-bundle reset: rst low after 9 samples, then 17 samples of 0x55 -> exactly one done_o; all S=0x55; bundle_cnt_o=1.
REQ-035 Downstream hookup: packer output drives the CI R8 stage with a 19-bundle frame -> CI progress_done_o asserts after the last bundle; no assertion errors.

Source files
------------

// File: rtl/mrelbp_pkg.sv
// Shared constants and FSM encoding for the MRELBP R8 sample packer.
package mrelbp_pkg;

    localparam int DATA_W_DEFAULT = 8;
    localparam int N_SAMPLES      = 17;
    localparam int LAST_SLOT      = N_SAMPLES - 1;
    localparam int IDX_W          = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

endpackage

// File: rtl/mrelbp_slot_counter.sv
// Slot index 0..16 for the sample packer; wraps after the last slot, clears on frame end.
module mrelbp_slot_counter
    import mrelbp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [IDX_W-1:0] idx,
    output logic             term,
    output logic             wrap
);

    assign term = (idx == IDX_W'(LAST_SLOT));
    assign wrap = inc && term;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
        end else if (clr || wrap) begin
            idx <= '0;
        end else if (inc) begin
            idx <= idx + 1'b1;
        end
    end

endmodule

// File: rtl/mrelbp_r8_sample_packer.sv
// Serial-to-parallel packer: 17 samples per bundle for the MRELBP CI R8 stage.
// Define MRELBP_SAMPLER_ZERO_PAD_EN to zero-pad and emit partial bundles at frame end.
module mrelbp_r8_sample_packer
    import mrelbp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_i,
    input  logic              valid_i,
    input  logic              last_i,
    output logic [DATA_W-1:0] S1,
    output logic [DATA_W-1:0] S2,
    output logic [DATA_W-1:0] S3,
    output logic [DATA_W-1:0] S4,
    output logic [DATA_W-1:0] S5,
    output logic [DATA_W-1:0] S6,
    output logic [DATA_W-1:0] S7,
    output logic [DATA_W-1:0] S8,
    output logic [DATA_W-1:0] S9,
    output logic [DATA_W-1:0] S10,
    output logic [DATA_W-1:0] S11,
    output logic [DATA_W-1:0] S12,
    output logic [DATA_W-1:0] S13,
    output logic [DATA_W-1:0] S14,
    output logic [DATA_W-1:0] S15,
    output logic [DATA_W-1:0] S16,
    output logic [DATA_W-1:0] S17,
    output logic              done_o,
    output logic              frame_done_o,
    output logic [CNT_W-1:0]  bundle_cnt_o,
    output logic              err_o
);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic              term;
    logic              wrap;
    logic              frame_end;
    logic              partial;
    logic              emit;
    logic              flag_err;

    logic [DATA_W-1:0] shadow      [LAST_SLOT];
    logic [DATA_W-1:0] bundle_q    [N_SAMPLES];
    logic [DATA_W-1:0] next_bundle [N_SAMPLES];

    assign frame_end = valid_i && last_i;
    assign partial   = frame_end && !term;

`ifdef MRELBP_SAMPLER_ZERO_PAD_EN
    assign emit     = wrap || partial;
    assign flag_err = 1'b0;
`else
    assign emit     = wrap;
    assign flag_err = partial;
`endif

    mrelbp_slot_counter u_slot_counter (
        .clk  (clk),
        .rst  (rst),
        .inc  (valid_i),
        .clr  (frame_end),
        .idx  (idx),
        .term (term),
        .wrap (wrap)
    );

    // Slots below idx come from the shadow, slot idx is the sample arriving now,
    // anything above is zero; a full bundle is just the idx==16 case.
    always_comb begin
        for (int k = 0; k < LAST_SLOT; k++) begin
            next_bundle[k] = '0;
            if (IDX_W'(k) < idx) begin
                next_bundle[k] = shadow[k];
            end else if (IDX_W'(k) == idx) begin
                next_bundle[k] = sample_i;
            end
        end
        next_bundle[LAST_SLOT] = term ? sample_i : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < LAST_SLOT; k++) begin
                shadow[k] <= '0;
            end
        end else if (valid_i && !term) begin
            shadow[idx[IDX_W-2:0]] <= sample_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            done_o       <= 1'b0;
            frame_done_o <= 1'b0;
            err_o        <= 1'b0;
            bundle_cnt_o <= '0;
            bundle_q     <= '{default: '0};
        end else begin
            done_o       <= emit;
            frame_done_o <= frame_end;
            if (flag_err) begin
                err_o <= 1'b1;
            end
            if (emit) begin
                bundle_q <= next_bundle;
            end

            case (state)
                ST_IDLE: if (valid_i) state <= frame_end ? ST_IDLE : ST_FILL;
                ST_FILL: if (frame_end) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            // A new frame restarts the count; a one-sample padded frame counts itself.
            if (state == ST_IDLE && valid_i) begin
                bundle_cnt_o <= emit ? CNT_W'(1) : '0;
            end else if (emit && bundle_cnt_o != '1) begin
                bundle_cnt_o <= bundle_cnt_o + 1'b1;
            end
        end
    end

    assign S1  = bundle_q[0];
    assign S2  = bundle_q[1];
    assign S3  = bundle_q[2];
    assign S4  = bundle_q[3];
    assign S5  = bundle_q[4];
    assign S6  = bundle_q[5];
    assign S7  = bundle_q[6];
    assign S8  = bundle_q[7];
    assign S9  = bundle_q[8];
    assign S10 = bundle_q[9];
    assign S11 = bundle_q[10];
    assign S12 = bundle_q[11];
    assign S13 = bundle_q[12];
    assign S14 = bundle_q[13];
    assign S15 = bundle_q[14];
    assign S16 = bundle_q[15];
    assign S17 = bundle_q[16];

endmodule

// File: tb/tb_mrelbp_r8_sample_packer.sv
// Bench for mrelbp_r8_sample_packer: directed scenarios plus random traffic against a queue model.
module tb_mrelbp_r8_sample_packer;

`ifdef MRELBP_SAMPLER_ZERO_PAD_EN
    localparam bit ZP = 1'b1;
`else
    localparam bit ZP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  sample_i;
    logic        valid_i;
    logic        last_i;
    logic [7:0]  S1, S2, S3, S4, S5, S6, S7, S8, S9, S10, S11, S12, S13, S14, S15, S16, S17;
    logic        done_o;
    logic        frame_done_o;
    logic [15:0] bundle_cnt_o;
    logic        err_o;

    logic [7:0]  s_obs [17];

    always #5 clk = ~clk;

    mrelbp_r8_sample_packer #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .sample_i(sample_i), .valid_i(valid_i), .last_i(last_i),
        .S1(S1), .S2(S2), .S3(S3), .S4(S4), .S5(S5), .S6(S6), .S7(S7), .S8(S8), .S9(S9),
        .S10(S10), .S11(S11), .S12(S12), .S13(S13), .S14(S14), .S15(S15), .S16(S16),
        .S17(S17), .done_o(done_o), .frame_done_o(frame_done_o),
        .bundle_cnt_o(bundle_cnt_o), .err_o(err_o)
    );

    always_comb begin
        s_obs[0]  = S1;  s_obs[1]  = S2;  s_obs[2]  = S3;  s_obs[3]  = S4;
        s_obs[4]  = S5;  s_obs[5]  = S6;  s_obs[6]  = S7;  s_obs[7]  = S8;
        s_obs[8]  = S9;  s_obs[9]  = S10; s_obs[10] = S11; s_obs[11] = S12;
        s_obs[12] = S13; s_obs[13] = S14; s_obs[14] = S15; s_obs[15] = S16;
        s_obs[16] = S17;
    end

    int n_assert = 0;
    int n_fail   = 0;
    int done_seen = 0;

    // Reference model: samples of the open bundle kept in a queue.
    logic [7:0]  cur [$];
    bit          in_frame;
    logic [7:0]  exp_S [17];
    logic        exp_done, exp_fd, exp_err;
    logic [15:0] exp_cnt;

    task automatic model_reset();
        cur.delete();
        in_frame = 1'b0;
        for (int k = 0; k < 17; k++) exp_S[k] = 8'h00;
        exp_done = 1'b0; exp_fd = 1'b0; exp_err = 1'b0; exp_cnt = 16'd0;
    endtask

    task automatic model_step(input logic v, input logic l, input logic [7:0] d);
        exp_done = 1'b0;
        exp_fd   = 1'b0;
        if (v) begin
            if (!in_frame) begin
                in_frame = 1'b1;
                exp_cnt  = 16'd0;
                cur.delete();
            end
            cur.push_back(d);
            if (cur.size() == 17 || l) begin
                if (cur.size() == 17 || ZP) begin
                    for (int k = 0; k < 17; k++) exp_S[k] = (k < cur.size()) ? cur[k] : 8'h00;
                    exp_done = 1'b1;
                    if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                end else begin
                    exp_err = 1'b1;
                end
                cur.delete();
            end
            if (l) begin
                exp_fd   = 1'b1;
                in_frame = 1'b0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        check({ph, ".done"},  32'(done_o),       32'(exp_done));
        check({ph, ".fdone"}, 32'(frame_done_o), 32'(exp_fd));
        check({ph, ".cnt"},   32'(bundle_cnt_o), 32'(exp_cnt));
        check({ph, ".err"},   32'(err_o),        32'(exp_err));
        for (int k = 0; k < 17; k++)
            check($sformatf("%s.S%0d", ph, k + 1), 32'(s_obs[k]), 32'(exp_S[k]));
    endtask

    task automatic step(input string ph, input logic v, input logic l, input logic [7:0] d);
        valid_i  = v;
        last_i   = l;
        sample_i = d;
        @(posedge clk);
        model_step(v, l, d);
        #1;
        if (done_o) done_seen++;
        check_all(ph);
    endtask

    task automatic apply_reset(input string ph);
        rst      = 1'b0;
        valid_i  = 1'b0;
        last_i   = 1'b0;
        sample_i = 8'h00;
        model_reset();
        #1;
        check_all(ph);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; valid_i = 1'b0; last_i = 1'b0; sample_i = 8'h00;
        model_reset();
        @(posedge clk);
        #1;
        apply_reset("por");

        // Ramp 10..170
        for (int i = 1; i <= 17; i++) step("ramp", 1'b1, 1'b0, 8'(10 * i));
        check("ramp.S1_lit", 32'(S1), 32'd10);
        check("ramp.S17_lit", 32'(S17), 32'd170);
        check("ramp.cnt_lit", 32'(bundle_cnt_o), 32'd1);
        step("ramp_idle", 1'b0, 1'b0, 8'h00);

        // Two full bundles in one frame
        apply_reset("rst_b2b");
        done_seen = 0;
        for (int i = 1; i <= 34; i++) begin
            step("b2b", 1'b1, (i == 34), 8'(i));
            if (i == 17) check("b2b.first_done", 32'(done_o), 32'd1);
        end
        check("b2b.S1_lit", 32'(S1), 32'd18);
        check("b2b.S17_lit", 32'(S17), 32'd34);
        check("b2b.fd_with_done", 32'({frame_done_o, done_o}), 32'b11);
        check("b2b.cnt_lit", 32'(bundle_cnt_o), 32'd2);
        check("b2b.done_count", 32'(done_seen), 32'd2);
        step("b2b_idle", 1'b0, 1'b0, 8'h00);

        // Gapped input
        apply_reset("rst_gap");
        done_seen = 0;
        for (int i = 1; i <= 17; i++) begin
            step("gap", 1'b1, 1'b0, 8'(10 * i));
            step("gap_hole", 1'b0, 1'b1, 8'hEE);
        end
        check("gap.S1_lit", 32'(S1), 32'd10);
        check("gap.S17_lit", 32'(S17), 32'd170);
        check("gap.done_count", 32'(done_seen), 32'd1);

        // Partial frame of five 7s
        apply_reset("rst_part");
        for (int i = 1; i <= 5; i++) step("part", 1'b1, (i == 5), 8'd7);
        check("part.err_lit", 32'(err_o), ZP ? 32'd0 : 32'd1);
        check("part.done_lit", 32'(done_o), ZP ? 32'd1 : 32'd0);
        check("part.S5_lit", 32'(S5), ZP ? 32'd7 : 32'd0);
        check("part.S6_lit", 32'(S6), 32'd0);
        step("part_idle", 1'b0, 1'b0, 8'h00);
        step("part_idle", 1'b0, 1'b0, 8'h00);

        // Reset in the middle of a bundle
        apply_reset("rst_mid0");
        for (int i = 1; i <= 9; i++) step("mid_pre", 1'b1, 1'b0, 8'(i));
        #2;
        apply_reset("rst_mid");
        done_seen = 0;
        for (int i = 1; i <= 17; i++) step("mid", 1'b1, 1'b0, 8'h55);
        for (int i = 0; i < 3; i++) step("mid_idle", 1'b0, 1'b0, 8'h00);
        check("mid.done_count", 32'(done_seen), 32'd1);
        check("mid.S9_lit", 32'(S9), 32'h55);
        check("mid.cnt_lit", 32'(bundle_cnt_o), 32'd1);

        // Random traffic with gaps, stray last_i and short/long frames
        apply_reset("rst_rand");
        for (int i = 0; i < 1500; i++) begin
            step("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0),
                 8'($urandom_range(0, 255)));
        end
        step("rand_tail", 1'b1, 1'b1, 8'hA5);
        step("rand_tail", 1'b0, 1'b0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
